gcd_param_unit: RTL and testbench
=================================

GCD_PARAM_UNIT -- requirements
Module: gcd_param_unit

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand and result bit width (minimum 2).
REQ-002 Parameter CNT_W, default 16, sets the iteration counter width; it is used only when GCD_ITER_CNT_EN is defined.
REQ-003 clk  input  1  The single clock; all state updates on the rising edge.
REQ-004 rst  input  1  Reset, synchronous and active-high.
REQ-005 start  input  1  Operation request; sampled only in IDLE.
REQ-006 a_in  input  WIDTH  Operand A; sampled on the accepting edge only.
REQ-007 b_in  input  WIDTH  Operand B; sampled on the accepting edge only.
REQ-008 busy  output  1  High from the accepting edge until done is asserted.
REQ-009 done  output  1  One-cycle completion pulse, registered.
REQ-010 result  output  WIDTH  GCD value; held stable from done until the next accepting edge.
REQ-011 zero_err  output  1  Set with done when both operands are 0; held with result.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 IDLE with start=1 SHALL be accepted at that edge: regA<=a_in, regB<=b_in, busy<=1, next state CALC.
REQ-014 start SHALL be ignored in CALC and DONE; there is no queuing of requests.
REQ-015 In CALC, each edge SHALL perform exactly one action, evaluated in this priority order:
 - A=0 and B=0: result<=0, zero_err<=1, terminate.
 - A=0: result<=B, terminate.
 - B=0: result<=A, terminate.
 - A=B: result<=A, terminate.
 - A>B: A<=A-B.
 - A<B: B<=B-A.
REQ-016 Subtraction SHALL be unsigned WIDTH-bit; because the larger value is always the minuend, no underflow can occur.
REQ-017 On a terminate edge, done<=1, busy<=0, and next state DONE; zero_err SHALL be cleared on any non-error terminate.
REQ-018 DONE SHALL last exactly one cycle: done<=0, next state IDLE; result and zero_err SHALL hold.
REQ-019 Latency: with start accepted at edge k and S subtraction steps, done SHALL be high between edges k+S+1 and k+S+2.
REQ-020 A new start SHALL be accepted at the first edge after done falls; the earliest back-to-back accept is two edges after the terminate edge.
REQ-021 The comparison and subtraction paths SHALL be combinational from regA and regB, with a single register stage per CALC step.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE and clear regA, regB, result, busy, done, zero_err (and iter_cnt when present) to 0, regardless of state.
REQ-023 rst SHALL take priority over start and over any CALC/DONE action on the same edge; an aborted operation SHALL produce no done pulse.

Configuration
REQ-024 Macro GCD_ITER_CNT_EN, when defined, SHALL add output port iter_cnt [CNT_W-1:0].
REQ-025 With the macro defined, iter_cnt SHALL behave as follows:
 - cleared on the accepting edge;
 - incremented on each subtraction step in CALC;
 - saturating at 2^CNT_W-1;
 - held after done until the next accept.
REQ-026 With the macro undefined, the iter_cnt port and its counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 WIDTH=16, a_in=48, b_in=18, start at edge k -> 4 steps; done high between k+5 and k+6; result=6; zero_err=0; iter_cnt=4.
REQ-028 a_in=25, b_in=25 -> done at k+1..k+2; result=25; iter_cnt=0. Also a_in=0, b_in=7 -> result=7 at k+1; zero_err=0.
REQ-029 a_in=0, b_in=0 -> done at k+1; result=0; zero_err=1. A following run with 12/18 -> result=6; zero_err=0.
REQ-030 a_in=65535, b_in=1 -> result=1 after 65534 steps; iter_cnt=65534. Rerun with CNT_W=8 -> iter_cnt saturates at 255.
REQ-031 Start 48/18; assert start with 9/3 during CALC -> 9/3 ignored and result=6. Then start 9/3 after done -> result=3.
REQ-032 Start 48/18; assert rst for one edge at k+2 -> all outputs 0, no done pulse. Start 12/18 next cycle -> result=6 with normal latency.

Source files
------------

// File: rtl/gcd_param_unit.sv
// Iterative subtract-based GCD engine with a three-state IDLE/CALC/DONE controller.
// Optional iteration counter output is enabled by defining GCD_ITER_CNT_EN.
module gcd_param_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_err
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [CNT_W-1:0] iter_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] reg_a, reg_b;
    logic [WIDTH-1:0] reg_a_next, reg_b_next, result_next;
    logic             busy_next, done_next, zero_err_next;
    logic             accept, sub_step;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next    = state;
        reg_a_next    = reg_a;
        reg_b_next    = reg_b;
        result_next   = result;
        busy_next     = busy;
        done_next     = done;
        zero_err_next = zero_err;
        accept        = 1'b0;
        sub_step      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    reg_a_next = a_in;
                    reg_b_next = b_in;
                    busy_next  = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                // Terminate cases share the done/busy handshake; only result and zero_err differ.
                if (reg_a == '0 || reg_b == '0 || reg_a == reg_b) begin
                    done_next     = 1'b1;
                    busy_next     = 1'b0;
                    zero_err_next = 1'b0;
                    state_next    = DONE;
                    if (reg_a == '0 && reg_b == '0) begin
                        result_next   = '0;
                        zero_err_next = 1'b1;
                    end else if (reg_a == '0) begin
                        result_next = reg_b;
                    end else begin
                        result_next = reg_a;
                    end
                end else if (reg_a > reg_b) begin
                    sub_step   = 1'b1;
                    reg_a_next = reg_a - reg_b;
                end else begin
                    sub_step   = 1'b1;
                    reg_b_next = reg_b - reg_a;
                end
            end
            DONE: begin
                done_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            reg_a    <= '0;
            reg_b    <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            zero_err <= 1'b0;
        end else begin
            state    <= state_next;
            reg_a    <= reg_a_next;
            reg_b    <= reg_b_next;
            result   <= result_next;
            busy     <= busy_next;
            done     <= done_next;
            zero_err <= zero_err_next;
        end
    end

`ifdef GCD_ITER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            iter_cnt <= '0;
        end else if (sub_step && iter_cnt != {CNT_W{1'b1}}) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = accept ^ sub_step;
`endif

endmodule

// File: tb/tb_gcd_param_unit.sv
// Self-checking bench for gcd_param_unit: vector table driven through a scoreboard,
// plus hand sequences for start-during-CALC and reset-abort. Honors GCD_ITER_CNT_EN.
module tb_gcd_param_unit;

    localparam int WIDTH  = 16;
    localparam int CNT_W  = 16;
    localparam int BUDGET = 70000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in, b_in;
    logic             busy, done, zero_err;
    logic [WIDTH-1:0] result;
`ifdef GCD_ITER_CNT_EN
    logic [CNT_W-1:0] iter_cnt;
`endif

    gcd_param_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero_err (zero_err)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_cnt (iter_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             zero;
        int               steps;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int res, input bit zero, input int steps);
        vec_t v;
        v.a     = a[WIDTH-1:0];
        v.b     = b[WIDTH-1:0];
        v.res   = res[WIDTH-1:0];
        v.zero  = zero;
        v.steps = steps;
        return v;
    endfunction

    // Completion monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("zero_err", 32'(zero_err), 32'(e.zero));
`ifdef GCD_ITER_CNT_EN
                check("iter_cnt", 32'(iter_cnt),
                      (e.steps > (2**CNT_W - 1)) ? (2**CNT_W - 1) : e.steps);
`endif
            end
        end
    end

    // One full operation; with hold set, start stays high with other operands during CALC.
    task automatic run_op(input vec_t v, input bit hold);
        int n;
        @(negedge clk);
        a_in  = v.a;
        b_in  = v.b;
        start = 1'b1;
        sb.push_back(v);
        @(posedge clk); #1;
        check("busy_after_accept", 32'(busy), 32'd1);
        if (hold) begin
            a_in = 16'd9;
            b_in = 16'd3;
        end else begin
            start = 1'b0;
        end
        n = 0;
        while (!done && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("latency", 32'(n), 32'(v.steps + 1));
        check("busy_low_at_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("result_hold", 32'(result), 32'(v.res));
        check("zero_err_hold", 32'(zero_err), 32'(v.zero));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;

        vecs.push_back(mk(48, 18, 6, 0, 4));
        vecs.push_back(mk(25, 25, 25, 0, 0));
        vecs.push_back(mk(0, 7, 7, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0));
        vecs.push_back(mk(12, 18, 6, 0, 2));
        vecs.push_back(mk(7, 0, 7, 0, 0));
        vecs.push_back(mk(17, 5, 1, 0, 6));
        vecs.push_back(mk(100, 75, 25, 0, 3));
        vecs.push_back(mk(65535, 1, 1, 0, 65534));

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_zero_err", 32'(zero_err), 32'd0);
`ifdef GCD_ITER_CNT_EN
        check("reset_iter_cnt", 32'(iter_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i], 1'b0);

        // start held during CALC/DONE must not spawn a second operation.
        run_op(mk(48, 18, 6, 0, 4), 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_queued_start", 32'(busy), 32'd0);
        end
        run_op(mk(9, 3, 3, 0, 2), 1'b0);

        // Reset two edges into a run aborts it without a done pulse.
        @(negedge clk);
        a_in  = 16'd48;
        b_in  = 16'd18;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_zero_err", 32'(zero_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op(mk(12, 18, 6, 0, 2), 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
